// File: rtl/spi_bus_target.sv
// spi_bus_target: mode-0 SPI target oversampled in the clk_i domain. It decodes
// command/address/data bytes into valid/ready bus transactions. Address width is
// configurable, reads and writes can burst with auto-increment, and overruns set
// a sticky error flag.
`timescale 1ns/1ps
module spi_bus_target #(
  parameter int         ADDR_WIDTH    = 17,
  parameter bit         BURST_EN      = 1'b1,
  parameter logic [7:0] RD_IDLE_VALUE = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_pico_i,
  output logic                  spi_poci_o,
  output logic [ADDR_WIDTH-1:0] spi_addr_o,
  output logic                  spi_rw_no,
  output logic [7:0]            spi_data_o,
  input  logic [7:0]            spi_data_i,
  output logic                  spi_valid_o,
  input  logic                  spi_ready_i,
  output logic                  spi_err_o
);
  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int ACW        = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RTURN, RDATA} state_t;

  state_t                state_q, state_d;
  logic [2:0]            sck_q, sck_d, cs_q, cs_d;     // [0]/[1] sync, [2] previous
  logic [1:0]            pico_q, pico_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            rx_q, rx_d;
  logic [7:0]            tx_q, tx_d;
  logic [ACW-1:0]        addr_cnt_q, addr_cnt_d;
  logic                  cmd_rd_q, cmd_rd_d;
  logic                  first_q, first_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  rd_avail_q, rd_avail_d;
  logic                  rd_discard_q, rd_discard_d;
  logic                  err_q, err_d;

  logic                  sck_rise, sck_fall, cs_fall, active, byte_done, addr_last;
  logic [7:0]            rx_byte;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic                  issue, iss_rw;
  logic [ADDR_WIDTH-1:0] iss_addr;

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign active    = (state_q != IDLE) && !cs_q[1];
  assign rx_byte   = {rx_q, pico_q[1]};
  assign byte_done = active && sck_rise && (bit_cnt_q == 3'd7);
  assign addr_last = (addr_cnt_q == ACW'(ADDR_BYTES - 1));

  // Address bytes arrive MSB first; bits above ADDR_WIDTH fall off the top.
  if (ADDR_WIDTH > 8) begin : g_wide
    assign addr_shift = {cur_addr_q[ADDR_WIDTH-9:0], rx_byte};
  end else begin : g_narrow
    assign addr_shift = rx_byte[ADDR_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: a high CS forces IDLE; otherwise advance on byte boundaries.
  always_comb begin
    state_d = state_q;
    if (cs_q[1]) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (cs_fall) state_d = CMD;
        CMD:   if (byte_done) begin
                 case (rx_byte[7:6])
                   2'b10:   state_d = WDATA;
                   2'b11:   state_d = RTURN;
                   default: state_d = ADDR;
                 endcase
               end
        ADDR:  if (byte_done && addr_last) state_d = cmd_rd_q ? RTURN : WDATA;
        RTURN: if (byte_done) state_d = RDATA;
        default: ;
      endcase
    end
  end

  // Datapath: shift registers, byte decode, transaction issue and handshake.
  always_comb begin
    sck_d        = {sck_q[1:0], spi_sck_i};
    cs_d         = {cs_q[1:0], spi_cs_ni};
    pico_d       = {pico_q[0], spi_pico_i};
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    addr_cnt_d   = addr_cnt_q;
    cmd_rd_d     = cmd_rd_q;
    first_d      = first_q;
    cur_addr_d   = cur_addr_q;
    next_addr_d  = next_addr_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    valid_d      = valid_q;
    rdata_d      = rdata_q;
    rd_avail_d   = rd_avail_q;
    rd_discard_d = rd_discard_q;
    err_d        = err_q;
    issue        = 1'b0;
    iss_rw       = 1'b1;
    iss_addr     = cur_addr_q;

    if (!active) begin
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_d      = rx_byte[6:0];
    end

    // The falling edge right after a byte boundary is skipped so the freshly
    // loaded MSB is still on poci when the MCU samples the next byte's first bit.
    if (state_q == IDLE && cs_fall) begin
      tx_d  = RD_IDLE_VALUE;
      err_d = 1'b0;
    end else if (active && sck_fall && bit_cnt_q != 3'd0) begin
      tx_d = {tx_q[6:0], 1'b1};
    end

    if (byte_done) begin
      tx_d = RD_IDLE_VALUE;
      case (state_q)
        CMD: begin
          cmd_rd_d   = rx_byte[6];
          addr_cnt_d = '0;
          first_d    = 1'b1;
          if (rx_byte[7]) begin
            cur_addr_d = next_addr_q;
            if (rx_byte[6] && !valid_q) begin
              issue    = 1'b1;
              iss_addr = next_addr_q;
            end
          end
        end
        ADDR: begin
          cur_addr_d = addr_shift;
          addr_cnt_d = addr_cnt_q + ACW'(1);
          if (addr_last && cmd_rd_q && !valid_q) begin
            issue    = 1'b1;
            iss_addr = addr_shift;
          end
        end
        WDATA: if (first_q || BURST_EN) begin
          first_d = 1'b0;
          if (valid_q) begin
            err_d = 1'b1;
          end else begin
            issue    = 1'b1;
            iss_rw   = 1'b0;
            iss_addr = cur_addr_q;
          end
        end
        RTURN, RDATA: if (state_q == RTURN || BURST_EN) begin
          if (rd_avail_q) begin
            tx_d       = rdata_q;
            rd_avail_d = 1'b0;
            if (BURST_EN && !valid_q) begin
              issue    = 1'b1;
              iss_addr = next_addr_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Completion; a read that outlived its frame is dropped here.
    if (valid_q && spi_ready_i) begin
      valid_d = 1'b0;
      if (rw_q) begin
        if (rd_discard_q) begin
          rd_discard_d = 1'b0;
        end else begin
          rdata_d    = spi_data_i;
          rd_avail_d = 1'b1;
        end
      end
    end

    if (cs_q[1] && !cs_q[2]) begin
      rd_avail_d   = 1'b0;
      rd_discard_d = valid_q && rw_q && !spi_ready_i;
    end

    if (issue) begin
      valid_d     = 1'b1;
      addr_d      = iss_addr;
      rw_d        = iss_rw;
      next_addr_d = iss_addr + ADDR_WIDTH'(1);
      cur_addr_d  = iss_addr + ADDR_WIDTH'(1);
      if (!iss_rw) wdata_d = rx_byte;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sck_q        <= '0;
      cs_q         <= '1;
      pico_q       <= '0;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '1;
      addr_cnt_q   <= '0;
      cmd_rd_q     <= 1'b0;
      first_q      <= 1'b0;
      cur_addr_q   <= '0;
      next_addr_q  <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b1;
      wdata_q      <= '0;
      valid_q      <= 1'b0;
      rdata_q      <= '0;
      rd_avail_q   <= 1'b0;
      rd_discard_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sck_q        <= sck_d;
      cs_q         <= cs_d;
      pico_q       <= pico_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      addr_cnt_q   <= addr_cnt_d;
      cmd_rd_q     <= cmd_rd_d;
      first_q      <= first_d;
      cur_addr_q   <= cur_addr_d;
      next_addr_q  <= next_addr_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      valid_q      <= valid_d;
      rdata_q      <= rdata_d;
      rd_avail_q   <= rd_avail_d;
      rd_discard_q <= rd_discard_d;
      err_q        <= err_d;
    end
  end

  assign spi_poci_o  = tx_q[7];
  assign spi_addr_o  = addr_q;
  assign spi_rw_no   = rw_q;
  assign spi_data_o  = wdata_q;
  assign spi_valid_o = valid_q;
  assign spi_err_o   = err_q;
endmodule

// File: tb/tb_spi_bus_target.sv
// Bench for spi_bus_target: table of SPI frames with expected MISO bytes and bus
// transactions, plus hand sequences for overrun and mid-byte abort.
`timescale 1ns/1ps
module tb_spi_bus_target;
  logic        clk = 1'b0, rst, sck, cs_n, pico, poci, rw_n, valid, ready, err;
  logic [16:0] addr;
  logic [7:0]  data_o, data_in;

  spi_bus_target dut (
    .clk_i(clk), .reset_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_pico_i(pico),
    .spi_poci_o(poci), .spi_addr_o(addr), .spi_rw_no(rw_n), .spi_data_o(data_o),
    .spi_data_i(data_in), .spi_valid_o(valid), .spi_ready_i(ready), .spi_err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               n;
    logic [47:0]      mosi;
    logic [47:0]      miso;
    int               ntx;
    logic [4:0][16:0] tx_addr;
    logic [4:0][7:0]  tx_data;
    logic             tx_rw;
    logic [7:0]       rd_start;
  } vec_t;

  vec_t vec [4];

  int checks = 0, errors = 0;
  int rdy_delay = 1, wait_cnt = 0;
  bit hold_rdy = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic [16:0] log_addr[$];
  logic        log_rw[$];
  logic [7:0]  log_data[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus side: answer each pending transaction after rdy_delay cycles unless held.
  initial begin
    ready = 1'b0;
    data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (ready) begin
        ready = 1'b0;
      end else if (valid && !hold_rdy) begin
        if (wait_cnt >= rdy_delay) begin
          ready = 1'b1;
          wait_cnt = 0;
          log_addr.push_back(addr);
          log_rw.push_back(rw_n);
          if (rw_n) begin
            data_in = rd_val;
            log_data.push_back(rd_val);
            rd_val = rd_val + 8'h01;
          end else begin
            log_data.push_back(data_o);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic spi_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      pico = mo[i];
      repeat (8) @(posedge clk);
      #1;
      mi[i] = poci;
      sck = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic cs_end();
    repeat (8) @(posedge clk);
    #1;
    cs_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic chk_txn(input string nm, input int idx, input logic [16:0] a,
                         input logic rw, input logic [7:0] d);
    if (idx < log_addr.size()) begin
      chk({nm, " addr"}, log_addr[idx], a);
      chk({nm, " rw"}, log_rw[idx], rw);
      chk({nm, " data"}, log_data[idx], d);
    end else begin
      chk({nm, " missing"}, idx, log_addr.size());
    end
  endtask

  initial begin
    logic [7:0] mi;
    int base;

    vec[0].name = "write_at"; vec[0].n = 5; vec[0].ntx = 1; vec[0].tx_rw = 1'b0;
    vec[0].mosi = {8'h00, 8'h01, 8'h23, 8'h45, 8'hA5, 8'h00};
    vec[0].miso = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec[0].tx_addr = '0; vec[0].tx_data = '0; vec[0].rd_start = 8'h00;
    vec[0].tx_addr[0] = 17'h12345; vec[0].tx_data[0] = 8'hA5;

    vec[1].name = "read_next_burst"; vec[1].n = 5; vec[1].ntx = 5; vec[1].tx_rw = 1'b1;
    vec[1].mosi = {8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[1].miso = {8'hFF, 8'hFF, 8'h10, 8'h11, 8'h12, 8'h00};
    vec[1].rd_start = 8'h10;
    for (int k = 0; k < 5; k++) begin
      vec[1].tx_addr[k] = 17'h12346 + 17'(k);
      vec[1].tx_data[k] = 8'h10 + 8'(k);
    end

    vec[2].name = "wrap"; vec[2].n = 6; vec[2].ntx = 2; vec[2].tx_rw = 1'b0;
    vec[2].mosi = {8'h00, 8'h01, 8'hFF, 8'hFF, 8'h01, 8'h02};
    vec[2].miso = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec[2].tx_addr = '0; vec[2].tx_data = '0; vec[2].rd_start = 8'h00;
    vec[2].tx_addr[0] = 17'h1FFFF; vec[2].tx_data[0] = 8'h01;
    vec[2].tx_addr[1] = 17'h00000; vec[2].tx_data[1] = 8'h02;

    vec[3].name = "read_at"; vec[3].n = 6; vec[3].ntx = 3; vec[3].tx_rw = 1'b1;
    vec[3].mosi = {8'h40, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    vec[3].miso = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h5A};
    vec[3].tx_addr = '0; vec[3].tx_data = '0; vec[3].rd_start = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      vec[3].tx_addr[k] = 17'h00010 + 17'(k);
      vec[3].tx_data[k] = 8'h5A + 8'(k);
    end

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; pico = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", valid, 1'b0);
    chk("reset rw_n", rw_n, 1'b1);
    chk("reset addr", addr, 17'h0);
    chk("reset poci", poci, 1'b1);
    chk("reset err", err, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      rd_val = vec[v].rd_start;
      base = log_addr.size();
      cs_begin();
      for (int b = 0; b < vec[v].n; b++) begin
        spi_bits(vec[v].mosi[47-8*b -: 8], 8, mi);
        chk($sformatf("%s miso[%0d]", vec[v].name, b), mi, vec[v].miso[47-8*b -: 8]);
      end
      cs_end();
      repeat (40) @(posedge clk);
      #1;
      chk({vec[v].name, " txn count"}, log_addr.size() - base, vec[v].ntx);
      for (int k = 0; k < vec[v].ntx; k++)
        chk_txn($sformatf("%s txn%0d", vec[v].name, k), base + k,
                vec[v].tx_addr[k], vec[v].tx_rw, vec[v].tx_data[k]);
      chk({vec[v].name, " err"}, err, 1'b0);
    end

    // Read overrun: ready withheld until the response byte is due.
    base = log_addr.size();
    hold_rdy = 1'b1;
    cs_begin();
    spi_bits(8'h40, 8, mi);
    spi_bits(8'h00, 8, mi);
    spi_bits(8'h00, 8, mi);
    spi_bits(8'h20, 8, mi);
    spi_bits(8'h00, 8, mi);
    spi_bits(8'h00, 8, mi);
    chk("rd_ovr miso", mi, 8'hFF);
    cs_end();
    chk("rd_ovr err", err, 1'b1);
    chk("rd_ovr valid held", valid, 1'b1);
    chk("rd_ovr addr", addr, 17'h00020);
    hold_rdy = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rd_ovr txn count", log_addr.size() - base, 1);
    chk("rd_ovr valid done", valid, 1'b0);
    chk("rd_ovr err sticky", err, 1'b1);

    // Abort mid address byte, then WRITE_NEXT to the unchanged next address.
    base = log_addr.size();
    cs_begin();
    chk("abort err cleared", err, 1'b0);
    spi_bits(8'h00, 8, mi);
    spi_bits(8'h12, 4, mi);
    cs_end();
    repeat (20) @(posedge clk);
    #1;
    chk("abort txn count", log_addr.size() - base, 0);
    chk("abort valid", valid, 1'b0);
    cs_begin();
    spi_bits(8'h80, 8, mi);
    spi_bits(8'h77, 8, mi);
    cs_end();
    repeat (40) @(posedge clk);
    #1;
    chk("wr_next txn count", log_addr.size() - base, 1);
    chk_txn("wr_next", base, 17'h00021, 1'b0, 8'h77);

    // Write overrun: second byte arrives while the first is still pending.
    base = log_addr.size();
    hold_rdy = 1'b1;
    cs_begin();
    spi_bits(8'h80, 8, mi);
    spi_bits(8'hAA, 8, mi);
    spi_bits(8'hBB, 8, mi);
    cs_end();
    chk("wr_ovr err", err, 1'b1);
    chk("wr_ovr data held", data_o, 8'hAA);
    hold_rdy = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("wr_ovr txn count", log_addr.size() - base, 1);
    chk_txn("wr_ovr", base, 17'h00022, 1'b0, 8'hAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_bus_target.md
Name: spi_bus_target

Overview:
- Parametrised successor to the single-address SPI1 target: oversamples a mode-0 SPI link from the MCU in the clk_i domain and decodes command/address/data bytes.
- Issues bus transactions over a valid/ready handshake: address, direction, write data out; read data back to the MCU.
- Adds configurable address width, multi-byte addressing, burst auto-increment within one chip-select, and a sticky error flag for handshake overrun.
- Sits between the MCU SPI pins and the bus arbiter.

Parameters:
ADDR_WIDTH, 17, width of spi_addr_o; address bytes per *_AT command = ceil(ADDR_WIDTH/8), MSB first, upper excess bits discarded.
BURST_EN, 1, 1 = extra data bytes in one CS frame repeat the op at address+1; 0 = extra bytes ignored.
RD_IDLE_VALUE, 8'hFF, byte shifted out when no read data is available.

Ports:
clk_i  in  1  system clock (64 MHz nominal).
reset_i  in  1  asynchronous, active-high reset.
spi_sck_i  in  1  SPI clock, asynchronous, idle low, at most clk_i/8.
spi_cs_ni  in  1  SPI chip select, active low, asynchronous.
spi_pico_i  in  1  MCU-to-target data, asynchronous.
spi_poci_o  out  1  target-to-MCU data.
spi_addr_o  out  ADDR_WIDTH  address of pending transaction.
spi_rw_no  out  1  1 = read, 0 = write.
spi_data_o  out  8  write data.
spi_data_i  in  8  read data, valid with spi_ready_i.
spi_valid_o  out  1  transaction pending.
spi_ready_i  in  1  transaction complete this cycle.
spi_err_o  out  1  sticky overrun flag; cleared by reset or by a CS falling edge.

Behaviour:
- Input sampling
  - sck, cs_n and pico each pass through a 2-FF synchroniser; edges are detected on the synchronised signals.
  - Bits are sampled on the sck rising edge, MSB first. A 3-bit counter marks byte completion.
- Output shifting
  - poci shifts on the sck falling edge.
  - At each byte boundary and at CS fall, the tx register is loaded and its MSB drives poci immediately.
- Reset values: spi_valid_o=0, spi_addr_o=0, spi_rw_no=1, spi_data_o=0, spi_poci_o=1, spi_err_o=0, next-address register=0, state=IDLE.
- Command byte
  - Bits [7:6] are the opcode: 00 WRITE_AT, 01 READ_AT, 10 WRITE_NEXT, 11 READ_NEXT. Bits [5:0] are reserved and ignored.
- States
  - IDLE: on CS fall, go to CMD.
  - CMD: on byte done, *_AT goes to ADDR; WRITE_NEXT goes to WDATA with addr=next address; READ_NEXT issues a read at next address and goes to RTURN.
  - ADDR: after ADDR_BYTES bytes, WRITE_AT goes to WDATA; READ_AT issues a read and goes to RTURN.
  - WDATA: each data byte issues a write at the current address.
  - RTURN: the turnaround byte; its content is ignored.
  - RDATA: at the end of the turnaround byte and each following byte boundary, the latched read data loads into tx.
- Handshake
  - When a transaction is issued, spi_valid_o rises the next clk_i cycle.
  - addr, rw_n and data_o stay stable until the cycle spi_ready_i=1 while spi_valid_o=1; valid falls the next cycle.
  - On a read, spi_data_i is latched in the ready cycle.
- Next-address register
  - Loaded with address+1 (modulo 2^ADDR_WIDTH, so all-ones wraps to 0) on each issued transaction.
  - Persists across CS frames.
- Burst (BURST_EN=1)
  - Writes: each additional WDATA byte issues a write at the next address.
  - Reads: loading a response byte into tx immediately issues a read at the next address, so a continuous frame returns consecutive addresses.
- Overrun
  - Applies when a read response is due and ready has not occurred, or a write byte completes while valid is still high.
  - Response: tx loads RD_IDLE_VALUE or the write byte is dropped; spi_err_o sets.
- CS rise mid-byte: the partial byte is discarded and the state returns to IDLE. A pending valid still completes its handshake (it is not aborted).
- CS rise with burst-prefetched read pending: the read completes and its data is discarded; the next-address register is still updated.
- Async reset mid-transaction: all state clears immediately, including valid.

Test Plan:
- Reset: reset_i=1 for 3 cycles -> spi_valid_o=0, spi_rw_no=1, spi_addr_o=0, spi_poci_o=1, spi_err_o=0.
- WRITE_AT: bytes 8'h00, 8'h01, 8'h23, 8'h45, 8'hA5 with ready 2 cycles after valid -> one write, addr=17'h12345, data=8'hA5, rw_n=0; next address=17'h12346.
- READ_NEXT burst: after the previous test, send 8'hC0 plus 4 dummy bytes; ready returns 8'h10, 8'h11, 8'h12 -> reads at 17'h12346, 17'h12347, 17'h12348; MISO bytes 2-4 = 8'h10, 8'h11, 8'h12.
- Wrap: WRITE_AT addr 17'h1FFFF with data 8'h01, 8'h02 in one frame -> writes at 17'h1FFFF then 17'h00000.
- Overrun: READ_AT with ready withheld -> response byte = 8'hFF, spi_err_o=1; next CS fall clears it.
- Abort: CS rises after 4 bits of an address byte -> no valid issued, state returns to IDLE; a following WRITE_NEXT targets the unchanged next address.
